// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle RV32M unit that sits beside the execute stage. It accepts one
//   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per request handshake.
//   Multiplies go through a short multiplier pipeline. Divides and remainders
//   go through a radix-2 restoring divider. The result is returned together
//   with the destination register. While the unit is busy, stall_o holds the
//   issue stage off.
//
// Parameters
//   XLEN         operand/result width (the divider performs XLEN steps)
//   MUL_LATENCY  cycles from the accept edge to resp_valid_o for MUL* (>=1)
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous reset, active-high
//   req_valid_i    request present
//   req_ready_o    unit can accept (idle)
//   req_op_i       funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_rs1_i      operand a
//   req_rs2_i      operand b
//   req_rd_i       destination register, returned unchanged
//   flush_i        kill the in-flight op; result is discarded
//   resp_valid_o   result available
//   resp_ready_i   consumer takes the result
//   resp_data_o    result
//   resp_rd_o      rd of the result
//   stall_o        high whenever the unit is not idle
//
// Configuration
//   MULDIV_DIV_EARLY_OUT_EN: when defined, trivial divides (divide by zero,
//   signed overflow, |rs1|<|rs2|) finish straight out of DIV_PREP, with a
//   latency of 2. When undefined, every DIV* op takes XLEN+2 cycles.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            stall_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_BUSY = 3'd1,
        S_DIV_PREP = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DIV_FIX  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    // Multiply result for ops 0..3: low half for MUL, high half otherwise.
    function automatic logic [XLEN-1:0] mul_result(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic              a_sgn;
        logic              b_sgn;
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        logic [2*XLEN-1:0] prod;
        a_sgn = (op == 3'd1) || (op == 3'd2);
        b_sgn = (op == 3'd1);
        a_ext = {{XLEN{a_sgn & a[XLEN-1]}}, a};
        b_ext = {{XLEN{b_sgn & b[XLEN-1]}}, b};
        prod  = a_ext * b_ext;
        if (op[1:0] == 2'd0) begin
            return prod[XLEN-1:0];
        end else begin
            return prod[2*XLEN-1:XLEN];
        end
    endfunction

    // One restoring-division step. quo shifts the remaining dividend bits out
    // at the top while quotient bits enter at the bottom. Returns {rem, quo}.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   rem_sh;
        logic [XLEN-1:0] diff;
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh[XLEN-1:0] - dvs;
        if (rem_sh >= {1'b0, dvs}) begin
            return {diff, quo[XLEN-2:0], 1'b1};
        end else begin
            return {rem_sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
        end
    endfunction

    // Two's-complement magnitude when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        if (neg) begin
            return {XLEN{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    state_e          state_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;
    logic [4:0]      resp_rd_q;
    logic            stall_q;

    logic            neg_a_d;
    logic            neg_b_d;
    logic            b_zero_d;
    logic [XLEN-1:0] abs_a_d;
    logic [XLEN-1:0] abs_b_d;
    logic [2*XLEN-1:0] prep_step_d;
    logic [2*XLEN-1:0] iter_step_d;
    logic [XLEN-1:0] mul_res_d;
    logic [XLEN-1:0] quot_d;
    logic [XLEN-1:0] remd_d;
    logic [XLEN-1:0] fix_res_d;
    logic            early_d;
    logic [XLEN-1:0] early_res_d;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic            overflow_d;
`endif

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_rd_o    = resp_rd_q;
    assign stall_o      = stall_q;

    // Datapath for the captured operands: multiplier output, divider step,
    // sign handling, the final sign fix-up and the optional early-out result.
    always_comb begin
        // Signed divide ops (DIV, REM) have funct3 bit 0 clear.
        neg_a_d     = ~op_q[0] & a_q[XLEN-1];
        neg_b_d     = ~op_q[0] & b_q[XLEN-1];
        b_zero_d    = (b_q == {XLEN{1'b0}});
        abs_a_d     = cond_neg(a_q, neg_a_d);
        abs_b_d     = cond_neg(b_q, neg_b_d);
        // DIV_PREP already performs the first step. That keeps the whole
        // divide at XLEN+2 cycles.
        prep_step_d = div_step({XLEN{1'b0}}, abs_a_d, abs_b_d);
        iter_step_d = div_step(rem_q, quo_q, dvs_q);
        mul_res_d   = mul_result(op_q, a_q, b_q);
        quot_d      = cond_neg(quo_q, neg_a_d ^ neg_b_d);
        remd_d      = cond_neg(rem_q, neg_a_d);
        // The divider alone would give 1 for a negative dividend over zero.
        // Force the architectural result for divide by zero instead.
        if (b_zero_d) begin
            quot_d = {XLEN{1'b1}};
            remd_d = a_q;
        end else begin
            quot_d = quot_d;
            remd_d = remd_d;
        end
        fix_res_d = op_q[1] ? remd_d : quot_d;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        overflow_d = ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}})
                              & (b_q == {XLEN{1'b1}});
        early_d    = b_zero_d | overflow_d | (abs_a_d < abs_b_d);
        if (b_zero_d) begin
            early_res_d = op_q[1] ? a_q : {XLEN{1'b1}};
        end else if (overflow_d) begin
            early_res_d = op_q[1] ? {XLEN{1'b0}} : a_q;
        end else begin
            early_res_d = op_q[1] ? a_q : {XLEN{1'b0}};
        end
`else
        early_d     = 1'b0;
        early_res_d = {XLEN{1'b0}};
`endif
    end

    // Sequencer FSM with registered handshake, stall and response outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            a_q          <= {XLEN{1'b0}};
            b_q          <= {XLEN{1'b0}};
            rd_q         <= 5'd0;
            cnt_q        <= 5'd0;
            rem_q        <= {XLEN{1'b0}};
            quo_q        <= {XLEN{1'b0}};
            dvs_q        <= {XLEN{1'b0}};
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= {XLEN{1'b0}};
            resp_rd_q    <= 5'd0;
            stall_q      <= 1'b0;
        end else if (flush_i) begin
            // Flush beats a same-cycle request and a same-cycle response handshake.
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        a_q         <= req_rs1_i;
                        b_q         <= req_rs2_i;
                        rd_q        <= req_rd_i;
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        if (req_op_i[2] == 1'b1) begin
                            state_q <= S_DIV_PREP;
                        end else if (MUL_LATENCY == 1) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= mul_result(req_op_i, req_rs1_i, req_rs2_i);
                            resp_rd_q    <= req_rd_i;
                        end else begin
                            state_q <= S_MUL_BUSY;
                            cnt_q   <= 5'(MUL_LATENCY - 2);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL_BUSY: begin
                    if (cnt_q == 5'd0) begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= mul_res_d;
                        resp_rd_q    <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV_PREP: begin
                    if (early_d) begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= early_res_d;
                        resp_rd_q    <= rd_q;
                    end else begin
                        state_q <= S_DIV_ITER;
                        rem_q   <= prep_step_d[2*XLEN-1:XLEN];
                        quo_q   <= prep_step_d[XLEN-1:0];
                        dvs_q   <= abs_b_d;
                        // The remaining XLEN-1 steps run with cnt = XLEN-2 .. 0.
                        cnt_q   <= 5'(XLEN - 2);
                    end
                end
                S_DIV_ITER: begin
                    rem_q <= iter_step_d[2*XLEN-1:XLEN];
                    quo_q <= iter_step_d[XLEN-1:0];
                    if (cnt_q == 5'd0) begin
                        state_q <= S_DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV_FIX: begin
                    state_q      <= S_DONE;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= fix_res_d;
                    resp_rd_q    <= rd_q;
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        stall_q      <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    stall_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer. Inputs are driven on the falling
//   edge and outputs are sampled on the falling edge. Expected results come
//   from a plain-arithmetic RV32M reference model or from literal constants.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        stall;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.XLEN(XLEN), .MUL_LATENCY(MUL_LAT)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_rd_i     (req_rd),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_rd_o    (resp_rd),
        .stall_o      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M reference result
    function automatic logic [31:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned up;
        int              ia;
        int              ib;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (ovf) return 32'h8000_0000;
                else return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    // Expected cycles from accept edge to first resp_valid
    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic        sgn;
        logic        special;
        if (op < 3'd4) return MUL_LAT;
        sgn     = (op == 3'd4) || (op == 3'd6);
        ma      = (sgn && a[31]) ? (32'd0 - a) : a;
        mb      = (sgn && b[31]) ? (32'd0 - b) : b;
        special = (b == 32'd0) || (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
                  || (ma < mb);
`ifdef MULDIV_DIV_EARLY_OUT_EN
        if (special) return 2;
        else return DIV_LAT;
`else
        if (special) return DIV_LAT;
        else return DIV_LAT;
`endif
    endfunction

    // Issue one op, check latency/result/rd, hold off resp_ready, then handshake.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_d, input int hold,
                          input bit garbage, input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] d0;
        logic [4:0]  r0;
        exp_lat = ref_latency(op, a, b);
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle-before-issue: req_ready=%b stall=%b want 1/0", tag, req_ready, stall);
        end
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        @(negedge clk);
        if (garbage) begin
            // Request still presented while busy, with different fields: must be ignored.
            req_op = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        checks++;
        if (stall !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy-flags: stall=%b req_ready=%b want 1/0", tag, stall, req_ready);
        end
        while (resp_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        checks++;
        if (resp_data !== exp_d || resp_rd !== rd) begin
            errors++;
            $display("FAIL %s result: data=%h rd=%0d want data=%h rd=%0d", tag, resp_data, resp_rd, exp_d, rd);
        end
        d0 = resp_data;
        r0 = resp_rd;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== d0 || resp_rd !== r0 ||
                req_ready !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b data=%h rd=%0d ready=%b stall=%b want 1 %h %0d 0 1",
                         tag, i, resp_valid, resp_data, resp_rd, req_ready, stall, d0, r0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s after-handshake: valid=%b ready=%b stall=%b want 0 1 0", tag, resp_valid, req_ready, stall);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s no-reaccept: stall=%b ready=%b want 0 1", tag, stall, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 ||
            resp_rd !== 5'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b data=%h rd=%0d stall=%b want 1 0 0 0 0",
                     req_ready, resp_valid, resp_data, resp_rd, stall);
        end
    endtask

    task automatic test_mul_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 0, 1'b0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 0, 1'b0, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 0, 1'b0, "mulhsu");
    endtask

    task automatic test_div_directed();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 0, 1'b0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 0, 1'b0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 0, 1'b0, "divu");
    endtask

    task automatic test_div_special();
        run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 1'b0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 0, 1'b0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1'b0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 1'b0, "rem_ovf");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFFF, 0, 1'b0, "div_neg_by0");
        run_op(3'd6, 32'hFFFF_FFFB, 32'd9, 5'd14, 32'hFFFF_FFFB, 0, 1'b0, "rem_small");
    endtask

    task automatic test_backpressure();
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 32'h0B00_EA4E, 5, 1'b0, "bp_mulhu");
        run_op(3'd5, 32'd1000, 32'd3, 5'd16, 32'd333, 5, 1'b1, "bp_divu_busyreq");
    endtask

    task automatic test_flush();
        bit seen;
        req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_div: valid=%b ready=%b stall=%b want 0 1 0", resp_valid, req_ready, stall);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || stall === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_quiet: activity after flush got 1 want 0");
        end
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd18, 32'd1, 0, 1'b0, "mulhu_after_flush");
        // Flush beats a same-cycle request.
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd2; req_rs2 = 32'd3;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        checks++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_vs_req: stall=%b ready=%b want 0 1", stall, req_ready);
        end
        // Flush in DONE drops the pending response.
        req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd2; req_rs2 = 32'd3; req_rd = 5'd19;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && resp_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_setup: valid=%b want 1", resp_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: valid=%b ready=%b stall=%b want 0 1 0", resp_valid, req_ready, stall);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 3'd4; req_rs1 = 32'd77; req_rs2 = 32'd5; req_rd = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd6; req_rs2 = 32'd7; req_rd = 5'd21;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 ||
            resp_rd !== 5'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%h rd=%0d stall=%b want 1 0 0 0 0",
                     req_ready, resp_valid, resp_data, resp_rd, stall);
        end
        reset = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (stall !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: stall=%b valid=%b want 0 0", stall, resp_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) a = a >> $urandom_range(8, 31);
            else if (sel == 3) b = b >> $urandom_range(16, 31);
            else a = a;
            run_op(op, a, b, 5'($urandom), ref_result(op, a, b),
                   $urandom_range(0, 3), 1'($urandom), $sformatf("rand%0d_op%0d", n, op));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
        req_rd = 5'd0; flush = 1'b0; resp_ready = 1'b0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_div_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
